// File: rtl/sig_rom_arbiter.sv
// Round-robin arbiter sharing one sigmoid ROM between numReq requesters; results return with a one-hot tag.
// Optional build macro SIG_ROM_ARB_PERF_EN adds saturating perf_grants / perf_stalls counters.
module sig_rom_arbiter #(
  parameter int numReq    = 4,
  parameter int inWidth   = 10,
  parameter int dataWidth = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [numReq-1:0]           req,
  input  logic [numReq*inWidth-1:0]   x_flat,
  output logic [numReq-1:0]           gnt,
  output logic [inWidth-1:0]          rom_x,
  input  logic [dataWidth-1:0]        rom_out,
  output logic [numReq-1:0]           res_valid,
  output logic [dataWidth-1:0]        res_data,
  output logic                        busy
`ifdef SIG_ROM_ARB_PERF_EN
  ,
  output logic [31:0]                 perf_grants,
  output logic [31:0]                 perf_stalls
`endif
);

  // Handshake: gnt[i] is high in the cycle x slice i is sampled; requester may
  // then drop req or present its next x. res_valid[i] is a one-cycle pulse
  // qualifying res_data for requester i, three cycles after its gnt.

  localparam int              TagW    = (numReq > 1) ? $clog2(numReq) : 1;
  localparam logic [TagW-1:0] LastIdx = TagW'(numReq - 1);

  logic [TagW-1:0]      r_ptr;
  logic [TagW-1:0]      r_s1_tag;
  logic [TagW-1:0]      r_s2_tag;
  logic                 r_s1_v;
  logic                 r_s2_v;
  logic [inWidth-1:0]   r_rom_x;
  logic [numReq-1:0]    r_res_valid;
  logic [dataWidth-1:0] r_res_data;

  logic [numReq-1:0]    w_gnt;
  logic [numReq-1:0]    w_tag_onehot;
  logic [TagW-1:0]      w_win;
  logic [TagW-1:0]      w_idx;
  logic                 w_any;
  logic                 w_seen;
  logic                 w_multi;
  logic [inWidth-1:0]   w_x;

  function automatic logic [TagW-1:0] wrap_idx(input logic [TagW-1:0] base, input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= 32'(numReq)) sum = sum - 32'(numReq);
    return TagW'(sum);
  endfunction

  // Search starts at the pointer and wraps explicitly at numReq-1.
  always_comb begin
    w_gnt = '0;
    w_win = '0;
    w_idx = '0;
    w_any = 1'b0;
    for (int i = 0; i < numReq; i++) begin
      w_idx = wrap_idx(r_ptr, i);
      if (!w_any && req[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
    if (rst) w_any = 1'b0;
    if (w_any) w_gnt[w_win] = 1'b1;
  end

  always_comb begin
    w_x = '0;
    for (int i = 0; i < numReq; i++) begin
      if (w_gnt[i]) w_x = x_flat[i*inWidth +: inWidth];
    end
  end

  always_comb begin
    w_tag_onehot = '0;
    w_tag_onehot[r_s2_tag] = 1'b1;
  end

  always_comb begin
    w_seen  = 1'b0;
    w_multi = 1'b0;
    for (int i = 0; i < numReq; i++) begin
      if (req[i]) begin
        if (w_seen) w_multi = 1'b1;
        w_seen = 1'b1;
      end
    end
  end

  // The ROM registers rom_x one edge after us; stage2 lines up with its data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_s1_tag    <= '0;
      r_s2_tag    <= '0;
      r_s1_v      <= 1'b0;
      r_s2_v      <= 1'b0;
      r_rom_x     <= '0;
      r_res_valid <= '0;
      r_res_data  <= '0;
    end else begin
      r_s1_v <= w_any;
      if (w_any) begin
        r_rom_x  <= w_x;
        r_s1_tag <= w_win;
        r_ptr    <= (w_win == LastIdx) ? '0 : w_win + 1'b1;
      end
      r_s2_v      <= r_s1_v;
      r_s2_tag    <= r_s1_tag;
      r_res_valid <= r_s2_v ? w_tag_onehot : '0;
      if (r_s2_v) r_res_data <= rom_out;
    end
  end

  assign gnt       = w_gnt;
  assign rom_x     = r_rom_x;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign busy      = r_s1_v | r_s2_v | (|r_res_valid);

`ifdef SIG_ROM_ARB_PERF_EN
  logic [31:0] r_perf_grants;
  logic [31:0] r_perf_stalls;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_grants <= '0;
      r_perf_stalls <= '0;
    end else begin
      if (w_any && (r_perf_grants != 32'hFFFF_FFFF)) r_perf_grants <= r_perf_grants + 32'd1;
      if (w_multi && (r_perf_stalls != 32'hFFFF_FFFF)) r_perf_stalls <= r_perf_stalls + 32'd1;
    end
  end

  assign perf_grants = r_perf_grants;
  assign perf_stalls = r_perf_stalls;
`else
  logic w_unused_multi;
  assign w_unused_multi = w_multi;
`endif

endmodule

// File: tb/tb_sig_rom_arbiter.sv
// Randomized + directed bench for sig_rom_arbiter against a cycle-level behavioural model.
module tb_sig_rom_arbiter;
  localparam int N  = 4;
  localparam int IW = 10;
  localparam int DW = 16;
  localparam int EW = 32 + 4 + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req    = '0;
  logic [N*IW-1:0] x_flat = '0;
  logic [N-1:0]    gnt;
  logic [IW-1:0]   rom_x;
  logic [DW-1:0]   rom_out;
  logic [N-1:0]    res_valid;
  logic [DW-1:0]   res_data;
  logic            busy;
`ifdef SIG_ROM_ARB_PERF_EN
  logic [31:0]     perf_grants;
  logic [31:0]     perf_stalls;
`endif

  sig_rom_arbiter #(.numReq(N), .inWidth(IW), .dataWidth(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .x_flat(x_flat), .gnt(gnt),
    .rom_x(rom_x), .rom_out(rom_out), .res_valid(res_valid),
    .res_data(res_data), .busy(busy)
`ifdef SIG_ROM_ARB_PERF_EN
    , .perf_grants(perf_grants), .perf_stalls(perf_stalls)
`endif
  );

  // ROM stand-in: registered address, y = x + 512 on a 10-bit field.
  logic [IW-1:0] rom_y;
  always @(posedge clk) rom_y <= rom_x + 10'h200;
  assign rom_out = {6'b0, rom_y};

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] sig_ref(input logic [IW-1:0] x);
    int v;
    v = int'($signed(x)) + 512;
    return DW'(v);
  endfunction

  logic [EW-1:0] exp_q[$];
  int            m_ptr = 0;
  logic [IW-1:0] m_rom_x = '0;
  logic [DW-1:0] m_rd = '0;
  logic [31:0]   m_pg = '0;
  logic [31:0]   m_ps = '0;
  int            wait_cnt[N];
  logic [N-1:0]  last_gnt = '0;

  logic [N-1:0]  e_gnt;
  logic [N-1:0]  e_rv;
  logic [DW-1:0] e_rd;
  logic [EW-1:0] e_head;
  bit            e_busy;
  int            e_w;
  int            e_idx;
  int            e_nreq;

  always @(negedge clk) begin
    if (chk_en) begin
      e_gnt = '0;
      e_w = -1;
      if (!rst) begin
        for (int k = 0; k < N; k++) begin
          e_idx = (m_ptr + k) % N;
          if (e_w < 0 && req[e_idx]) e_w = e_idx;
        end
      end
      if (e_w >= 0) e_gnt[e_w] = 1'b1;

      e_rv = '0;
      e_rd = m_rd;
      if (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) == cyc) begin
        e_head = exp_q.pop_front();
        e_rv[e_head[DW+3:DW]] = 1'b1;
        e_rd = e_head[DW-1:0];
        m_rd = e_rd;
      end
      e_busy = (e_rv != '0);
      foreach (exp_q[j]) if (int'(exp_q[j][EW-1 -: 32]) - 2 <= cyc) e_busy = 1'b1;

      chk("gnt", 32'(gnt), 32'(e_gnt));
      chk("rom_x", 32'(rom_x), 32'(m_rom_x));
      chk("res_valid", 32'(res_valid), 32'(e_rv));
      chk("res_data", 32'(res_data), 32'(e_rd));
      chk("busy", 32'(busy), 32'(e_busy));
`ifdef SIG_ROM_ARB_PERF_EN
      chk("perf_grants", perf_grants, m_pg);
      chk("perf_stalls", perf_stalls, m_ps);
`endif
      e_nreq = 0;
      for (int i = 0; i < N; i++) begin
        if (req[i]) e_nreq++;
        if (rst || !req[i] || gnt[i]) wait_cnt[i] = 0;
        else wait_cnt[i] = wait_cnt[i] + 1;
        if (req[i]) chk("starve", 32'(wait_cnt[i] < N), 32'd1);
      end

      if (rst) begin
        exp_q.delete();
        m_ptr = 0;
        m_rom_x = '0;
        m_rd = '0;
        m_pg = '0;
        m_ps = '0;
      end else begin
        if (e_w >= 0) begin
          exp_q.push_back({32'(cyc + 3), 4'(e_w), sig_ref(x_flat[e_w*IW +: IW])});
          m_rom_x = x_flat[e_w*IW +: IW];
          m_ptr = (e_w + 1) % N;
          if (m_pg != 32'hFFFF_FFFF) m_pg = m_pg + 1;
        end
        if (e_nreq > 1 && m_ps != 32'hFFFF_FFFF) m_ps = m_ps + 1;
      end
      last_gnt = gnt;
      cyc++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_x(input int i, input logic [IW-1:0] v);
    x_flat[i*IW +: IW] = v;
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    drive_edge();
    rst = 1'b1;
    req = '0;
    drive_edge();
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    drive_edge();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_rom_x", 32'(rom_x), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // single request, x = 0
    drive_edge();
    rst = 1'b0;
    req = 4'b0001;
    set_x(0, 10'h000);
    @(negedge clk);
    chk("t1_gnt", 32'(gnt), 32'h1);
    drive_edge();
    req = '0;
    @(negedge clk);
    chk("t1_rom_x", 32'(rom_x), 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("t1_res_valid", 32'(res_valid), 32'h1);
    chk("t1_res_data", 32'(res_data), 32'd512);
    @(negedge clk);
    chk("t1_busy_low", 32'(busy), 32'd0);

    // x = -1 on requester 2
    drive_edge();
    req = 4'b0100;
    set_x(2, 10'h3FF);
    @(negedge clk);
    chk("t2_gnt", 32'(gnt), 32'h4);
    drive_edge();
    req = '0;
    repeat (3) @(negedge clk);
    chk("t2_res_valid", 32'(res_valid), 32'h4);
    chk("t2_res_data", 32'(res_data), 32'd511);

    // all four requesting, round-robin from 0
    pulse_reset();
    drive_edge();
    for (int i = 0; i < N; i++) set_x(i, 10'(i * 100 + 7));
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t3_gnt", 32'(gnt), 32'(1 << (k % 4)));
      drive_edge();
      set_x(k % 4, 10'(k * 37 + 5));
    end
    req = '0;
    repeat (5) @(negedge clk);

    // requesters 1 and 3, pointer wraps 3 -> 0
    pulse_reset();
    drive_edge();
    req = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t4_gnt", 32'(gnt), (k % 2 == 0) ? 32'h2 : 32'h8);
      drive_edge();
    end
    req = '0;
    repeat (5) @(negedge clk);

    // reset with two lookups in flight
    pulse_reset();
    drive_edge();
    set_x(0, 10'h011);
    set_x(1, 10'h022);
    req = 4'b0011;
    @(negedge clk);
    chk("t5_gnt0", 32'(gnt), 32'h1);
    drive_edge();
    req = 4'b0010;
    @(negedge clk);
    chk("t5_gnt1", 32'(gnt), 32'h2);
    drive_edge();
    req = '0;
    rst = 1'b1;
    @(negedge clk);
    drive_edge();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t5_no_res", 32'(res_valid), 32'h0);
    end
    drive_edge();
    req = 4'b0001;
    set_x(0, 10'h055);
    @(negedge clk);
    chk("t5_gnt_after", 32'(gnt), 32'h1);
    drive_edge();
    req = '0;
    repeat (3) @(negedge clk);
    chk("t5_res_valid", 32'(res_valid), 32'h1);
    chk("t5_res_data", 32'(res_data), 32'h0255);

    // randomized traffic honouring the hold-until-grant contract
    for (int c = 0; c < 3000; c++) begin
      drive_edge();
      rst = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < N; i++) begin
        if (!req[i] || last_gnt[i]) begin
          req[i] = ($urandom_range(0, 3) != 0);
          set_x(i, 10'($urandom));
        end
      end
    end
    drive_edge();
    rst = 1'b0;
    req = '0;
    repeat (6) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
